// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, reset fetch address and the NOP encoding.
package cpu_pkg;
    localparam int          CPU_ADDR_WIDTH  = 8;
    localparam int          CPU_INSTR_WIDTH = 32;
    localparam int          CPU_RESET_PC    = 0;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding {instruction, pc} pairs between fetch and decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_INSTR_WIDTH + CPU_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_pop;

    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];
    assign do_pop     = pop & head_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

    // The upstream credit rule must never let a push land on a full buffer.
    assert property (@(posedge clk) disable iff (!reset_n) !(push && !flush && count == 2'd2));
endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: sequential PC generation, 1-cycle-latency imem reads,
// a 2-entry output buffer and redirect (branch/jump) flush.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = CPU_ADDR_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter int RESET_PC    = CPU_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   imem_rd_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready
);
    localparam int ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic                  inflight;
    logic                  kill;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    logic [2:0]            limit;
    logic [ENTRY_W-1:0]    head_data;

    // Handshake: an instruction moves to decode in a cycle where instr_valid and
    // instr_ready are both 1; instr_valid never depends on instr_ready.
    assign pop = instr_valid & instr_ready;

    // Credit check: buffered + in-flight, minus the one leaving now, must stay below 2.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign limit     = 3'd2 + {2'b00, pop};
    assign issue     = reset_n & ~redirect & (occupancy < limit);

    // A redirect kills the response of the read issued in the previous cycle.
    assign kill = redirect & inflight;
    assign push = inflight & ~kill;

    assign imem_rd_en = issue;
    assign imem_addr  = pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= ADDR_WIDTH'(RESET_PC);
            resp_pc  <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc      <= pc + ADDR_WIDTH'(1);
                resp_pc <= pc;
            end
        end
    end

    fetch_fifo #(.WIDTH(ENTRY_W)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect),
        .push       (push),
        .push_data  ({imem_rdata, resp_pc}),
        .pop        (pop),
        .head_valid (instr_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign {instr, instr_pc} = head_data;
endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: directed scenarios plus a randomized run against a stream-level model.
// dut_a starts at pc 0; dut_w starts at 0xFE to exercise address wrap.
module tb_cpu_fetch;
    logic        clk;
    logic        reset_n;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        instr_ready;

    logic        rd_en_a, rd_en_w;
    logic [7:0]  addr_a, addr_w;
    logic [31:0] rdata_a, rdata_w;
    logic        valid_a, valid_w;
    logic [31:0] instr_a, instr_w;
    logic [7:0]  pc_a, pc_w;

    int          n_cmp;
    int          n_fail;
    logic [7:0]  exp_q[$];

    cpu_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .imem_rd_en(rd_en_a), .imem_addr(addr_a),
        .imem_rdata(rdata_a), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(valid_a), .instr(instr_a), .instr_pc(pc_a), .instr_ready(instr_ready)
    );

    cpu_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(254)) dut_w (
        .clk(clk), .reset_n(reset_n), .imem_rd_en(rd_en_w), .imem_addr(addr_w),
        .imem_rdata(rdata_w), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(valid_w), .instr(instr_w), .instr_pc(pc_w), .instr_ready(instr_ready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'h1000_0000 + {24'h0, a};
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        rdata_a <= rd_en_a ? mem_word(addr_a) : $urandom;
        rdata_w <= rd_en_w ? mem_word(addr_w) : $urandom;
    end

    // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
    task automatic restart(input logic ready);
        @(negedge clk);
        reset_n = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        instr_ready = ready;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (valid_a !== 1'b0 || rd_en_a !== 1'b0 || instr_a !== 32'h0 || pc_a !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b rd_en=%b instr=%h pc=%h, required all zero", valid_a, rd_en_a, instr_a, pc_a);
        end
        n_cmp++;
        if (valid_w !== 1'b0 || rd_en_w !== 1'b0 || instr_w !== 32'h0 || pc_w !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_w: valid=%b rd_en=%b instr=%h pc=%h, required all zero", valid_w, rd_en_w, instr_w, pc_w);
        end
    endtask

    task automatic test_stream();
        logic [7:0] e;
        restart(1'b1);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        for (int c = 0; c < 12; c++) begin
            #1;
            n_cmp++;
            if (rd_en_a !== 1'b1 || addr_a !== 8'(c)) begin
                n_fail++;
                $display("FAIL stream_issue c%0d: rd_en=%b addr=%h, required 1 %h", c, rd_en_a, addr_a, 8'(c));
            end
            n_cmp++;
            if (valid_a !== (c >= 2)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: valid=%b, required %b", c, valid_a, (c >= 2));
            end
            if (valid_a && instr_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_sb c%0d: extra pc=%h, required none", c, pc_a);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_a !== e || instr_a !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL stream_sb c%0d: pc=%h instr=%h, required %h %h", c, pc_a, instr_a, e, mem_word(e));
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        int issues;
        issues = 0;
        restart(1'b0);
        for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
        for (int c = 0; c < 19; c++) begin
            instr_ready = (c >= 7);
            #1;
            if (c < 7) begin
                if (rd_en_a) issues++;
                n_cmp++;
                if (rd_en_a !== (c < 2) || (c < 2 && addr_a !== 8'(c))) begin
                    n_fail++;
                    $display("FAIL bp_issue c%0d: rd_en=%b addr=%h, required %b %h", c, rd_en_a, addr_a, (c < 2), 8'(c));
                end
            end
            if (c >= 2 && c < 7) begin
                n_cmp++;
                if (valid_a !== 1'b1 || pc_a !== 8'h00) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d: valid=%b pc=%h, required 1 00", c, valid_a, pc_a);
                end
            end
            if (c >= 7) begin
                n_cmp++;
                if (exp_q.size() == 0 || !(valid_a && instr_ready)) begin
                    n_fail++;
                    $display("FAIL bp_sb c%0d: valid=%b pc=%h, required a transfer", c, valid_a, pc_a);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_a !== e || instr_a !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL bp_sb c%0d: pc=%h instr=%h, required %h %h", c, pc_a, instr_a, e, mem_word(e));
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (issues != 2) begin
            n_fail++;
            $display("FAIL bp_count: %0d reads while stalled, required 2", issues);
        end
    endtask

    task automatic test_redirect_stream();
        logic [7:0] e;
        restart(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        for (int c = 0; c < 14; c++) begin
            redirect = (c == 6);
            redirect_pc = (c == 6) ? 8'h40 : 8'h00;
            #1;
            if (c == 6) begin
                n_cmp++;
                if (rd_en_a !== 1'b0 || exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL rs_cycle: rd_en=%b pending=%0d, required 0 0", rd_en_a, exp_q.size());
                end
                for (int i = 0; i < 5; i++) exp_q.push_back(8'h40 + 8'(i));
            end
            if (c == 7) begin
                n_cmp++;
                if (rd_en_a !== 1'b1 || addr_a !== 8'h40) begin
                    n_fail++;
                    $display("FAIL rs_restart: rd_en=%b addr=%h, required 1 40", rd_en_a, addr_a);
                end
            end
            if (c >= 7) begin
                n_cmp++;
                if (valid_a !== (c >= 9)) begin
                    n_fail++;
                    $display("FAIL rs_valid c%0d: valid=%b, required %b", c, valid_a, (c >= 9));
                end
            end
            if (c != 6 && valid_a && instr_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rs_sb c%0d: extra pc=%h, required none", c, pc_a);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_a !== e || instr_a !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL rs_sb c%0d: pc=%h instr=%h, required %h %h", c, pc_a, instr_a, e, mem_word(e));
                    end
                end
            end
            @(negedge clk);
        end
        redirect = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rs_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_full();
        logic [7:0] e;
        restart(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 + 8'(i));
        for (int c = 0; c < 13; c++) begin
            redirect = (c == 6);
            redirect_pc = 8'h80;
            instr_ready = (c >= 7);
            #1;
            if (c == 6) begin
                n_cmp++;
                if (valid_a !== 1'b1 || pc_a !== 8'h00 || rd_en_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rf_full: valid=%b pc=%h rd_en=%b, required 1 00 0", valid_a, pc_a, rd_en_a);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (rd_en_a !== 1'b1 || addr_a !== 8'h80 || valid_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rf_restart: rd_en=%b addr=%h valid=%b, required 1 80 0", rd_en_a, addr_a, valid_a);
                end
            end
            if (c >= 8) begin
                n_cmp++;
                if (valid_a !== (c >= 9)) begin
                    n_fail++;
                    $display("FAIL rf_valid c%0d: valid=%b, required %b", c, valid_a, (c >= 9));
                end
            end
            if (c >= 7 && valid_a && instr_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rf_sb c%0d: extra pc=%h, required none", c, pc_a);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_a !== e || instr_a !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL rf_sb c%0d: pc=%h instr=%h, required %h %h", c, pc_a, instr_a, e, mem_word(e));
                    end
                end
            end
            @(negedge clk);
        end
        redirect = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rf_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        restart(1'b1);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
        for (int c = 0; c < 13; c++) begin
            redirect = (c == 5) || (c == 6);
            redirect_pc = (c == 5) ? 8'h10 : 8'h20;
            #1;
            if (c == 5 || c == 6) begin
                n_cmp++;
                if (rd_en_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_noissue c%0d: rd_en=%b, required 0", c, rd_en_a);
                end
            end
            if (c == 6) for (int i = 0; i < 4; i++) exp_q.push_back(8'h20 + 8'(i));
            if (c == 7) begin
                n_cmp++;
                if (rd_en_a !== 1'b1 || addr_a !== 8'h20) begin
                    n_fail++;
                    $display("FAIL b2b_restart: rd_en=%b addr=%h, required 1 20", rd_en_a, addr_a);
                end
            end
            if (c != 5 && c != 6 && valid_a && instr_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_sb c%0d: extra pc=%h, required none", c, pc_a);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_a !== e || instr_a !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL b2b_sb c%0d: pc=%h instr=%h, required %h %h", c, pc_a, instr_a, e, mem_word(e));
                    end
                end
            end
            @(negedge clk);
        end
        redirect = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] e;
        restart(1'b1);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        for (int c = 0; c < 11; c++) begin
            reset_n = (c != 6);
            #1;
            if (c == 0 || c == 7) begin
                n_cmp++;
                if (rd_en_w !== 1'b1 || addr_w !== 8'hFE) begin
                    n_fail++;
                    $display("FAIL wrap_start c%0d: rd_en=%b addr=%h, required 1 fe", c, rd_en_w, addr_w);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (rd_en_w !== 1'b0 || exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL wrap_rst: rd_en=%b pending=%0d, required 0 0", rd_en_w, exp_q.size());
                end
                exp_q.push_back(8'hFE);
                exp_q.push_back(8'hFF);
            end
            if (c == 7 || c == 8) begin
                n_cmp++;
                if (valid_w !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_flush c%0d: valid=%b, required 0", c, valid_w);
                end
            end
            if (c != 6 && valid_w && instr_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_sb c%0d: extra pc=%h, required none", c, pc_w);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_w !== e || instr_w !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL wrap_sb c%0d: pc=%h instr=%h, required %h %h", c, pc_w, instr_w, e, mem_word(e));
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    // Stream model: consumer sees next_out, next_out+1, ... since the last redirect;
    // reads go out in order from next_iss, and issued-but-unconsumed never exceeds 2.
    task automatic test_random();
        logic [7:0] next_out;
        logic [7:0] next_iss;
        int ahead;
        restart(1'b1);
        next_out = 8'h00;
        next_iss = 8'h00;
        ahead = 0;
        for (int c = 0; c < 600; c++) begin
            redirect = ($urandom_range(0, 24) == 0);
            redirect_pc = 8'($urandom_range(0, 255));
            instr_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (redirect) begin
                n_cmp++;
                if (rd_en_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_redirect c%0d: rd_en=%b, required 0", c, rd_en_a);
                end
                next_out = redirect_pc;
                next_iss = redirect_pc;
                ahead = 0;
            end else begin
                if (valid_a && instr_ready) begin
                    n_cmp++;
                    if (pc_a !== next_out || instr_a !== mem_word(next_out)) begin
                        n_fail++;
                        $display("FAIL rnd_out c%0d: pc=%h instr=%h, required %h %h", c, pc_a, instr_a, next_out, mem_word(next_out));
                    end
                    next_out = next_out + 8'd1;
                    ahead--;
                end
                n_cmp++;
                if (rd_en_a !== (ahead < 2)) begin
                    n_fail++;
                    $display("FAIL rnd_credit c%0d: rd_en=%b, required %b", c, rd_en_a, (ahead < 2));
                end
                if (rd_en_a) begin
                    n_cmp++;
                    if (addr_a !== next_iss) begin
                        n_fail++;
                        $display("FAIL rnd_addr c%0d: addr=%h, required %h", c, addr_a, next_iss);
                    end
                    next_iss = next_iss + 8'd1;
                    ahead++;
                end
            end
            @(negedge clk);
        end
        redirect = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stream();
        test_redirect_full();
        test_back_to_back();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the decode/execute logic inside cpu_full.
- Generates sequential PCs and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes the buffer and any in-flight read.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; the PC is word-addressed.
- INSTR_WIDTH, 32: instruction word width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_rd_en  output  1  read strobe to instruction memory.
- imem_addr  output  ADDR_WIDTH  read address, valid when imem_rd_en=1.
- imem_rdata  input  INSTR_WIDTH  read data, valid exactly 1 cycle after imem_rd_en.
- redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch address, sampled when redirect=1.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr  output  INSTR_WIDTH  FIFO head instruction.
- instr_pc  output  ADDR_WIDTH  address of the FIFO head instruction.
- instr_ready  input  1  decode accepts the head; a transfer occurs when instr_valid and instr_ready are both 1.

Behaviour:
- Reset (reset_n=0 at a clock edge) sets: pc=RESET_PC, FIFO count=0, inflight=0, instr_valid=0, imem_rd_en=0, instr=0, instr_pc=0. Reset mid-operation discards all buffered and in-flight data; a response arriving in the cycle after reset is ignored.
- Issue rule, evaluated each cycle when reset_n=1 and redirect=0:
  - imem_rd_en=1 when count + inflight - pop < 2, where pop = instr_valid & instr_ready.
  - imem_addr=pc.
  - On issue: pc <= pc+1, wrapping modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 goes to 0), and inflight <= 1, with the address recorded as resp_pc.
  - With no issue, inflight <= 0.
- Response: in the cycle after an issue that was not killed, {imem_rdata, resp_pc} is pushed into the FIFO tail. The FIFO is never full at push time; this is guaranteed by the credit rule, and an assertion checks it.
- Output: instr/instr_pc/instr_valid come from the FIFO head, driven directly from registers with no combinational path from instr_ready.
- Push and pop in the same cycle are both performed; count is unchanged.
- Latency: rd_en at cycle N, push at end of N+1, instr_valid=1 at N+2.
- Throughput: 1 instruction/cycle with instr_ready held high.
- Backpressure: with instr_ready=0, at most 2 instructions are buffered and fetch stalls. pc does not advance while stalled, and no read is issued.
- Redirect:
  - Has priority over everything except reset.
  - In the redirect cycle: imem_rd_en=0, FIFO count <= 0 (the head is discarded even if instr_ready=1), pc <= redirect_pc.
  - A read issued in the previous cycle is killed (kill flag), and its response is not pushed.
  - The first read of redirect_pc is issued in the cycle after redirect; the first valid output appears 2 cycles after that.
  - Back-to-back redirects: the last one wins.
- Sequential behaviour throughout: the FIFO uses a 1-bit read pointer, a 1-bit write pointer and a 2-bit count, all wrapping naturally.

Decomposition:
- Shared package cpu_pkg (extend it if it already exists) holds ADDR_WIDTH/INSTR_WIDTH defaults, RESET_PC and NOP encoding constants; this block needs no typedefs beyond those.
- One natural sub-module: fetch_fifo, a 2-entry synchronous FIFO with push/pop/flush, count, and head data of width INSTR_WIDTH+ADDR_WIDTH.
- The PC/credit/kill logic stays in cpu_fetch.

Test Plan:
- Reset then instr_ready=1, memory word[i]=0x1000_0000+i:
  - imem_addr 0,1,2,… on consecutive cycles starting in the first cycle after reset release.
  - instr_valid rises 2 cycles later, with instr=0x1000_0000, instr_pc=0, then one instruction per cycle.
- Backpressure: instr_ready=0 from the first valid cycle for 5 cycles:
  - Exactly 2 reads are issued (addr 0,1), then imem_rd_en=0 and the head stays instr_pc=0.
  - After instr_ready=1 the outputs are pcs 0,1,2,… with no gaps or duplicates.
- Redirect while streaming: redirect=1, redirect_pc=0x40 at cycle 6:
  - imem_rd_en=0 that cycle, and the in-flight response is dropped.
  - The next rd_en has addr 0x40; the next instr_valid shows instr_pc=0x40; no pre-redirect pc ever appears after the flush.
- Redirect with instr_ready=0 and FIFO full: both entries are discarded and the output resumes at redirect_pc.
- Back-to-back redirects: 0x10 then 0x20 on consecutive cycles: the output starts at 0x20, and 0x10 is never issued to the consumer.
- Wrap and mid-run reset:
  - RESET_PC=0xFE, ADDR_WIDTH=8: the output pc sequence is 0xFE, 0xFF, 0x00, 0x01.
  - reset_n=0 for 1 cycle mid-stream: instr_valid=0 the next cycle, and fetch restarts at 0xFE.
